// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus: single outstanding request, req/gnt accept, in-order rvalid response.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch-side memory front end: requests the word at PCF, buffers the response and stalls
// the Fetch stage until the buffered word matches PCF; drops wrong-path responses.
module ifetch_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PCF,
  input  logic                 StallF,
  input  logic                 PCSrcE,
  ifetch_unit_if.master        imem,
  output logic [31:0]          InstrF,
  output logic                 FetchStallF,
  output logic                 fetch_err
);

  localparam logic [7:0] wdogLast = 8'(TIMEOUT - 1);
  localparam logic [7:0] wdogMax  = 8'hFF;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HAVE
  } fetchState_t;

  fetchState_t stateReg;
  logic [31:0] bufInstrReg;
  logic [31:0] bufPcReg;
  logic        dropReg;
  logic [7:0]  wdogReg;
  logic        fetchErrReg;

  logic        hit;
  logic        present;
  logic        dropNow;

  // A redirect in the current cycle invalidates the buffered word even if the PC matches.
  assign hit     = (bufPcReg == PCF) && !PCSrcE;
  assign present = reset && (stateReg == HAVE) && hit;
  assign dropNow = dropReg || PCSrcE;

  assign imem.imem_req  = reset && (stateReg == REQ);
  assign imem.imem_addr = {PCF[31:2], 2'b00};
  assign InstrF         = present ? bufInstrReg : NOP;
  assign FetchStallF    = !present;
  assign fetch_err      = fetchErrReg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg    <= REQ;
      dropReg     <= 1'b0;
      wdogReg     <= 8'd0;
      fetchErrReg <= 1'b0;
      bufInstrReg <= NOP;
      bufPcReg    <= 32'd0;
    end else begin
      case (stateReg)
        REQ: begin
          if (imem.imem_gnt) begin
            bufPcReg <= PCF;
            wdogReg  <= 8'd0;
            stateReg <= WAIT;
            if (PCSrcE) dropReg <= 1'b1;
          end
        end

        WAIT: begin
          if (imem.imem_rvalid) begin
            if (dropNow) begin
              dropReg  <= 1'b0;
              stateReg <= REQ;
            end else begin
              bufInstrReg <= imem.imem_rdata;
              stateReg    <= HAVE;
            end
          end else begin
            if (PCSrcE) dropReg <= 1'b1;
            if (wdogReg != wdogMax) wdogReg <= wdogReg + 8'd1;
            // Error is sticky; a late response is still accepted afterwards.
            if (wdogReg == wdogLast) fetchErrReg <= 1'b1;
          end
        end

        HAVE: begin
          // Leave on a miss, or once the datapath has consumed the word.
          if (!hit || !StallF) stateReg <= REQ;
        end

        default: stateReg <= REQ;
      endcase
    end
  end

endmodule
